// File: rtl/mpu_pkg.sv
// Shared matrix-unit constants and the element indexing helper used by the
// tile loader and its row selector.
package mpu_pkg;

  localparam int MPU_CHUNK_BITS = 512;
  localparam int MPU_ELEM_BITS  = 8;
  localparam int MPU_TILE_DIM   = 8;

  // Linear element index of (r,c) inside a row-major tile; element 0 is the chunk LSB.
  function automatic int idx(input int r, input int c, input int dim = MPU_TILE_DIM);
    return r * dim + c;
  endfunction

endpackage

// File: rtl/tile_row_select.sv
// Combinational row/column extractor: picks row row_idx of a tile, or column
// row_idx when the tile is flagged as transposed.
module tile_row_select
  import mpu_pkg::*;
#(
  parameter int elem_bits = MPU_ELEM_BITS,
  parameter int dim       = MPU_TILE_DIM,
  localparam int idx_bits = (dim > 1) ? $clog2(dim) : 1
) (
  input  logic [dim*dim*elem_bits-1:0] tile,
  input  logic [idx_bits-1:0]          row_idx,
  input  logic                         tr,
  output logic [dim*elem_bits-1:0]     row
);

  always_comb begin
    row = '0;
    for (int c = 0; c < dim; c++) begin
      if (tr)
        row[c*elem_bits +: elem_bits] = tile[idx(c, int'(row_idx), dim)*elem_bits +: elem_bits];
      else
        row[c*elem_bits +: elem_bits] = tile[idx(int'(row_idx), c, dim)*elem_bits +: elem_bits];
    end
  end

endmodule

// File: rtl/chunk_tile_loader.sv
// Two-slot tile buffer between the local-memory chunk port and the matrix
// datapath; streams one row (or column) per cycle over valid/ready.
module chunk_tile_loader
  import mpu_pkg::*;
#(
  parameter int num_bits  = MPU_CHUNK_BITS,
  parameter int elem_bits = MPU_ELEM_BITS,
  parameter int dim       = MPU_TILE_DIM,
  localparam int idx_bits = (dim > 1) ? $clog2(dim) : 1,
  localparam int row_bits = dim * elem_bits
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic [num_bits-1:0] chunk_in,
  input  logic                chunk_valid,
  input  logic                chunk_tr,
  output logic                chunk_ready,
  output logic [row_bits-1:0] row_out,
  output logic                row_valid,
  input  logic                row_ready,
  output logic [idx_bits-1:0] row_idx,
  output logic                tile_last,
  output logic [15:0]         tiles_done,
  output logic                busy
);

  generate
    if (num_bits != dim * dim * elem_bits) begin : g_bad_geometry
      $error("chunk_tile_loader: num_bits must equal dim*dim*elem_bits");
    end
  endgenerate

  localparam logic [idx_bits-1:0] last_row = idx_bits'(dim - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and chunk_ready never depends on row_ready.
  logic [num_bits-1:0] slot [2];
  logic [1:0]          tr_slot;
  logic [1:0]          count;
  logic                wr_ptr;
  logic                rd_ptr;
  logic                push;
  logic                pop_row;
  logic                pop_tile;
  logic [row_bits-1:0] sel_row;

  assign chunk_ready = (count != 2'd2) && !clear;
  assign push        = chunk_valid && chunk_ready;
  assign row_valid   = (count != 2'd0);
  assign busy        = row_valid;
  assign pop_row     = row_valid && row_ready;
  assign pop_tile    = pop_row && (row_idx == last_row);
  assign tile_last   = row_valid && (row_idx == last_row);

  // Storage has no reset; it is only ever read through a slot marked full by count.
  always_ff @(posedge clk) begin
    if (push) begin
      slot[wr_ptr]    <= chunk_in;
      tr_slot[wr_ptr] <= chunk_tr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= 2'd0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      row_idx    <= '0;
      tiles_done <= 16'd0;
    end else if (clear) begin
      count   <= 2'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      row_idx <= '0;
    end else begin
      if (push)
        wr_ptr <= ~wr_ptr;
      if (pop_row)
        row_idx <= pop_tile ? '0 : row_idx + idx_bits'(1);
      if (pop_tile) begin
        rd_ptr     <= ~rd_ptr;
        tiles_done <= tiles_done + 16'd1;
      end
      case ({push, pop_tile})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  tile_row_select #(
    .elem_bits(elem_bits),
    .dim      (dim)
  ) u_row_select (
    .tile   (slot[rd_ptr]),
    .row_idx(row_idx),
    .tr     (tr_slot[rd_ptr]),
    .row    (sel_row)
  );

  assign row_out = row_valid ? sel_row : '0;

endmodule

// File: tb/tb_chunk_tile_loader.sv
// Bench for chunk_tile_loader: directed tile scenarios plus randomized traffic,
// checked every cycle against a tile-queue model of the loader.
module tb_chunk_tile_loader;

  localparam int NB = 512;
  localparam int EB = 8;
  localparam int D  = 8;
  localparam int RB = D * EB;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clear = 1'b0;
  logic [NB-1:0] chunk_in = '0;
  logic          chunk_valid = 1'b0;
  logic          chunk_tr = 1'b0;
  logic          chunk_ready;
  logic [RB-1:0] row_out;
  logic          row_valid;
  logic          row_ready = 1'b0;
  logic [2:0]    row_idx;
  logic          tile_last;
  logic [15:0]   tiles_done;
  logic          busy;

  always #5 clk = ~clk;

  chunk_tile_loader dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .chunk_in   (chunk_in),
    .chunk_valid(chunk_valid),
    .chunk_tr   (chunk_tr),
    .chunk_ready(chunk_ready),
    .row_out    (row_out),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .row_idx    (row_idx),
    .tile_last  (tile_last),
    .tiles_done (tiles_done),
    .busy       (busy)
  );

  // Model: queue of buffered tiles {tr, data}, current row within head tile, drained count.
  logic [NB:0] exp_q[$];
  int          cur_row = 0;
  logic [15:0] exp_done = 16'd0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic        prev_stall = 1'b0;
  logic [RB-1:0] prev_row = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic [RB-1:0] exp_row(input logic [NB-1:0] t, input logic tr, input int r);
    logic [RB-1:0] res;
    int e;
    res = '0;
    for (int c = 0; c < D; c++) begin
      e = tr ? (c * D + r) : (r * D + c);
      res[c*EB +: EB] = t[e*EB +: EB];
    end
    return res;
  endfunction

  function automatic logic [NB-1:0] rand_chunk();
    logic [NB-1:0] v;
    for (int i = 0; i < NB / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [NB-1:0] ramp_chunk();
    logic [NB-1:0] v;
    for (int k = 0; k < NB / 8; k++) v[k*8 +: 8] = 8'(k);
    return v;
  endfunction

  always @(posedge clk) begin : model
    bit do_pop;
    bit do_push;
    if (!rst) begin
      do_pop  = !clear && exp_q.size() > 0 && row_ready;
      do_push = !clear && chunk_valid && exp_q.size() < 2;
      if (clear) begin
        exp_q.delete();
        cur_row = 0;
      end else begin
        if (do_pop) begin
          cur_row++;
          if (cur_row == D) begin
            cur_row = 0;
            exp_q.delete(0);
            exp_done++;
          end
        end
        if (do_push) exp_q.push_back({chunk_tr, chunk_in});
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [RB-1:0] er;
    logic ev;
    ev = exp_q.size() > 0;
    er = '0;
    if (ev) er = exp_row(exp_q[0][NB-1:0], exp_q[0][NB], cur_row);
    check("row_valid", row_valid, ev);
    check("chunk_ready", chunk_ready, exp_q.size() < 2 && !clear);
    check("row_out", row_out, er);
    check("row_idx", row_idx, cur_row);
    check("tile_last", tile_last, ev && cur_row == D - 1);
    check("tiles_done", tiles_done, exp_done);
    check("busy", busy, ev);
    if (prev_stall && !rst) check("row_hold", row_out, prev_row);
    prev_stall = row_valid && !row_ready && !clear && !rst;
    prev_row   = row_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int start;
    int cyc;
    #1 rst = 1'b1;
    #2;
    check("rst_valid", row_valid, 0);
    check("rst_ready", chunk_ready, 1);
    check("rst_out", row_out, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Single row-major ramp tile
    chunk_in = ramp_chunk(); chunk_tr = 1'b0; chunk_valid = 1'b1; row_ready = 1'b1;
    tick();
    chunk_valid = 1'b0;
    check("t2_row0", row_out, 64'h0706050403020100);
    for (int r = 0; r < D; r++) begin
      check("t2_idx", row_idx, r);
      check("t2_lsb", row_out[7:0], 8 * r);
      check("t2_last", tile_last, r == D - 1);
      if (r == D - 1) check("t2_row7", row_out, 64'h3f3e3d3c3b3a3938);
      tick();
    end
    check("t2_done", tiles_done, 1);
    check("t2_idle", row_valid, 0);

    // Same tile, transposed
    chunk_tr = 1'b1; chunk_valid = 1'b1;
    tick();
    chunk_valid = 1'b0;
    check("t3_row0", row_out, 64'h3830282018100800);
    for (int r = 0; r < D; r++) begin
      check("t3_lsb", row_out[7:0], r);
      if (r == D - 1) check("t3_row7", row_out, 64'h3f372f271f170f07);
      tick();
    end
    check("t3_done", tiles_done, 2);

    // Backpressure: two tiles fill the buffer, third waits
    row_ready = 1'b0; chunk_tr = 1'b0; chunk_valid = 1'b1;
    chunk_in = rand_chunk(); tick();
    chunk_in = rand_chunk(); tick();
    chunk_in = rand_chunk();
    check("t4_full", chunk_ready, 0);
    repeat (3) tick();
    check("t4_held_ready", chunk_ready, 0);
    check("t4_held_idx", row_idx, 0);
    row_ready = 1'b1;
    for (int k = 0; k < 3 * D; k++) begin
      check("t4_nogap", row_valid, 1);
      if (k == D - 1) check("t4_ready_lo", chunk_ready, 0);
      if (k == D) check("t4_ready_hi", chunk_ready, 1);
      tick();
      if (k == D) chunk_valid = 1'b0;
    end
    check("t4_done", tiles_done, 5);
    check("t4_empty", row_valid, 0);
    row_ready = 1'b0;

    // clear with two tiles buffered, mid-tile
    chunk_valid = 1'b1;
    chunk_in = rand_chunk(); tick();
    chunk_in = rand_chunk(); tick();
    chunk_valid = 1'b0; row_ready = 1'b1;
    repeat (3) tick();
    check("t6_mid_idx", row_idx, 3);
    clear = 1'b1; chunk_valid = 1'b1; chunk_in = rand_chunk();
    check("t6_ready_clr", chunk_ready, 0);
    tick();
    clear = 1'b0; chunk_valid = 1'b0;
    check("t6_valid", row_valid, 0);
    check("t6_idx", row_idx, 0);
    check("t6_done", tiles_done, 5);
    check("t6_busy", busy, 0);
    repeat (2) tick();
    check("t6_not_taken", row_valid, 0);
    row_ready = 1'b0;

    // Randomized traffic: 100 tiles with random transpose and consumer stalls
    start = int'(exp_done);
    cyc = 0;
    while (int'(exp_done) < start + 100 && cyc < 20000) begin
      chunk_valid = ($urandom_range(0, 3) != 0);
      chunk_in    = rand_chunk();
      chunk_tr    = 1'($urandom_range(0, 1));
      row_ready   = ($urandom_range(0, 2) != 0);
      tick();
      cyc++;
    end
    check("t5_tiles_done", tiles_done, 16'(start + 100));

    // Reset while a tile is streaming
    chunk_valid = 1'b1; chunk_in = rand_chunk(); row_ready = 1'b1;
    tick();
    chunk_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    exp_q.delete(); cur_row = 0; exp_done = 16'd0;
    #1;
    check("t1_valid", row_valid, 0);
    check("t1_ready", chunk_ready, 1);
    check("t1_done", tiles_done, 0);
    check("t1_busy", busy, 0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
